// File: rtl/ist_pkg.sv
// rtl/ist_pkg.sv - shared ist datatypes, field offsets and t compare helper
package ist_pkg;

    localparam int RID_W        = 4;
    localparam int CNT_W        = 8;
    localparam int T_W          = 32;

    // Offsets of the response fields relative to the end of the rid field.
    localparam int HIT_OFS      = 0;
    localparam int T_OFS        = 1;
    localparam int U_OFS        = T_OFS + T_W;
    localparam int V_OFS        = U_OFS + T_W;
    localparam int RESP_EXTRA_W = 1 + 3 * T_W;
    localparam int JOB_EXTRA_W  = T_W;

    typedef struct packed {
        logic [T_W-1:0]   v;
        logic [T_W-1:0]   u;
        logic [T_W-1:0]   t;
        logic             hit;
        logic [RID_W-1:0] rid;
    } ist_resp_t;

    typedef struct packed {
        logic [T_W-1:0]   t_max;
        logic [CNT_W-1:0] cnt;
        logic [RID_W-1:0] rid;
    } ist_job_t;

    // t is a non-negative IEEE single, so integer ordering matches float ordering.
    function automatic logic t_lt(input logic [T_W-1:0] a, input logic [T_W-1:0] b);
        return a < b;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - one-entry valid/ready pipeline register
module stream_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    assign in_rdy = !rst && (!out_vld || out_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/ist_hit_reduce.sv
// rtl/ist_hit_reduce.sv - per-ray closest-hit reduction of the ist response stream
module ist_hit_reduce
    import ist_pkg::*;
#(
    parameter int RID_WIDTH = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    job_vld,
    output logic                                    job_rdy,
    input  logic [RID_WIDTH+CNT_WIDTH+JOB_EXTRA_W-1:0] job_dat,
    input  logic                                    ist_resp_stream_rsc_vld,
    output logic                                    ist_resp_stream_rsc_rdy,
    input  logic [RID_WIDTH+RESP_EXTRA_W-1:0]       ist_resp_stream_rsc_dat,
    output logic                                    hit_vld,
    input  logic                                    hit_rdy,
    output logic [RID_WIDTH+RESP_EXTRA_W-1:0]       hit_dat,
    output logic                                    err
);

    localparam int N  = 2 ** RID_WIDTH;
    localparam int DW = RID_WIDTH + RESP_EXTRA_W;

    logic [N-1:0]           busy;
    logic [N-1:0]           found;
    logic [CNT_WIDTH-1:0]   rem    [N];
    logic [T_W-1:0]         best_t [N];
    logic [T_W-1:0]         best_u [N];
    logic [T_W-1:0]         best_v [N];

    logic [RID_WIDTH-1:0]   j_rid;
    logic [CNT_WIDTH-1:0]   j_cnt;
    logic [T_W-1:0]         j_tmax;
    logic [RID_WIDTH-1:0]   r_rid;
    logic                   r_hit;
    logic [T_W-1:0]         r_t;
    logic [T_W-1:0]         r_u;
    logic [T_W-1:0]         r_v;

    assign j_rid  = job_dat[0 +: RID_WIDTH];
    assign j_cnt  = job_dat[RID_WIDTH +: CNT_WIDTH];
    assign j_tmax = job_dat[RID_WIDTH + CNT_WIDTH +: T_W];
    assign r_rid  = ist_resp_stream_rsc_dat[0 +: RID_WIDTH];
    assign r_hit  = ist_resp_stream_rsc_dat[RID_WIDTH + HIT_OFS];
    assign r_t    = ist_resp_stream_rsc_dat[RID_WIDTH + T_OFS +: T_W];
    assign r_u    = ist_resp_stream_rsc_dat[RID_WIDTH + U_OFS +: T_W];
    assign r_v    = ist_resp_stream_rsc_dat[RID_WIDTH + V_OFS +: T_W];

    logic          o_in_vld;
    logic          o_in_rdy;
    logic [DW-1:0] o_in_dat;

    logic          resp_fire;
    logic          resp_live;
    logic          resp_last;
    logic          job_fire;
    logic          job_empty;
    logic          upd;
    logic          nxt_found;
    logic [T_W-1:0] nxt_t;
    logic [T_W-1:0] nxt_u;
    logic [T_W-1:0] nxt_v;

    // Reduction result including the response being accepted this cycle.
    assign upd       = r_hit && t_lt(r_t, best_t[r_rid]);
    assign nxt_found = found[r_rid] || upd;
    assign nxt_t     = upd ? r_t : best_t[r_rid];
    assign nxt_u     = upd ? r_u : best_u[r_rid];
    assign nxt_v     = upd ? r_v : best_v[r_rid];

    assign ist_resp_stream_rsc_rdy = o_in_rdy;
    assign resp_fire = ist_resp_stream_rsc_vld && o_in_rdy;
    assign resp_live = resp_fire && busy[r_rid];
    assign resp_last = resp_live && (rem[r_rid] == CNT_WIDTH'(1));

    // A completing response owns the output register, so it blocks any job that cycle.
    assign job_rdy   = o_in_rdy && !busy[j_rid] && !resp_last;
    assign job_fire  = job_vld && job_rdy;
    assign job_empty = (j_cnt == '0);

    always_comb begin
        o_in_vld = resp_last || (job_fire && job_empty);
        o_in_dat = '0;
        if (resp_last) begin
            o_in_dat[0 +: RID_WIDTH] = r_rid;
            if (nxt_found) begin
                o_in_dat[RID_WIDTH + HIT_OFS]      = 1'b1;
                o_in_dat[RID_WIDTH + T_OFS +: T_W] = nxt_t;
                o_in_dat[RID_WIDTH + U_OFS +: T_W] = nxt_u;
                o_in_dat[RID_WIDTH + V_OFS +: T_W] = nxt_v;
            end
        end else begin
            o_in_dat[0 +: RID_WIDTH] = j_rid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= '0;
            found <= '0;
            err   <= 1'b0;
        end else begin
            if (resp_fire && !busy[r_rid]) begin
                err <= 1'b1;
            end
            if (resp_live) begin
                rem[r_rid]    <= rem[r_rid] - CNT_WIDTH'(1);
                best_t[r_rid] <= nxt_t;
                best_u[r_rid] <= nxt_u;
                best_v[r_rid] <= nxt_v;
                found[r_rid]  <= nxt_found;
                if (resp_last) begin
                    busy[r_rid] <= 1'b0;
                end
            end
            // The job only ever targets an idle entry, so it never collides with resp_live.
            if (job_fire && !job_empty) begin
                busy[j_rid]   <= 1'b1;
                rem[j_rid]    <= j_cnt;
                best_t[j_rid] <= j_tmax;
                best_u[j_rid] <= '0;
                best_v[j_rid] <= '0;
                found[j_rid]  <= 1'b0;
            end
        end
    end

    stream_out_reg #(
        .W(DW)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (o_in_vld),
        .in_rdy  (o_in_rdy),
        .in_dat  (o_in_dat),
        .out_vld (hit_vld),
        .out_rdy (hit_rdy),
        .out_dat (hit_dat)
    );

endmodule

// File: tb/tb_ist_hit_reduce.sv
// tb/tb_ist_hit_reduce.sv - self-checking bench for ist_hit_reduce
module tb_ist_hit_reduce;
    import ist_pkg::*;

    localparam int RW = 4;
    localparam int CW = 8;
    localparam int N  = 16;
    localparam int DW = RW + 97;
    localparam int JW = RW + CW + 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_vld;
    logic          job_rdy;
    logic [JW-1:0] job_dat;
    logic          resp_vld;
    logic          resp_rdy;
    logic [DW-1:0] resp_dat;
    logic          hit_vld;
    logic          hit_rdy;
    logic [DW-1:0] hit_dat;
    logic          err;

    ist_hit_reduce #(.RID_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .job_vld                 (job_vld),
        .job_rdy                 (job_rdy),
        .job_dat                 (job_dat),
        .ist_resp_stream_rsc_vld (resp_vld),
        .ist_resp_stream_rsc_rdy (resp_rdy),
        .ist_resp_stream_rsc_dat (resp_dat),
        .hit_vld                 (hit_vld),
        .hit_rdy                 (hit_rdy),
        .hit_dat                 (hit_dat),
        .err                     (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per ray, the list of responses seen so far; the closest hit is found by scanning at completion.
    typedef struct { logic hit; logic [31:0] t; logic [31:0] u; logic [31:0] v; } rec_t;
    rec_t          m_q [N][$];
    logic [N-1:0]  m_open;
    int            m_cnt  [N];
    logic [31:0]   m_tmax [N];
    logic          m_vld;
    logic          m_err;
    logic [DW-1:0] m_dat;

    typedef struct {
        logic jv; int jrid; int jcnt; logic [31:0] jt;
        logic rv; int rrid; logic rh; logic [31:0] rt;
        logic ev; int erid; logic eh; logic [31:0] et;
    } vec_t;
    vec_t vt [17];

    logic [31:0] tset [4];
    logic [DW-1:0] saved;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int rid, input logic h, input logic [31:0] t,
                                         input logic [31:0] u, input logic [31:0] v);
        ist_resp_t s;
        s.rid = RW'(rid);
        s.hit = h;
        s.t   = t;
        s.u   = u;
        s.v   = v;
        return s;
    endfunction

    function automatic logic [DW-1:0] best_of(input int r);
        logic [31:0] bt = m_tmax[r];
        logic [31:0] bu = 32'h0;
        logic [31:0] bv = 32'h0;
        logic        f  = 1'b0;
        foreach (m_q[r][i]) begin
            if (m_q[r][i].hit && m_q[r][i].t < bt) begin
                bt = m_q[r][i].t;
                bu = m_q[r][i].u;
                bv = m_q[r][i].v;
                f  = 1'b1;
            end
        end
        return f ? mk(r, 1'b1, bt, bu, bv) : mk(r, 1'b0, 32'h0, 32'h0, 32'h0);
    endfunction

    task automatic step(input logic r, input logic jv, input int jrid, input int jcnt, input logic [31:0] jt,
                        input logic vv, input int rrid, input logic rh, input logic [31:0] rt, input logic hr);
        logic [31:0]   ru  = $urandom;
        logic [31:0]   rvv = $urandom;
        logic          free, erdy_r, erdy_j, rf, jf, rc, take, nv;
        logic [DW-1:0] nd;
        @(negedge clk);
        rst      = r;
        job_vld  = jv;
        job_dat  = {jt, CW'(jcnt), RW'(jrid)};
        resp_vld = vv;
        resp_dat = mk(rrid, rh, rt, ru, rvv);
        hit_rdy  = hr;
        #1;
        free   = !m_vld || hr;
        erdy_r = !r && free;
        rf     = vv && erdy_r;
        rc     = rf && m_open[rrid] && (m_q[rrid].size() + 1 == m_cnt[rrid]);
        erdy_j = !r && !m_open[jrid] && free && !rc;
        jf     = jv && erdy_j;
        chk("resp_rdy", resp_rdy, erdy_r);
        chk("job_rdy", job_rdy, erdy_j);
        chk("hit_vld", hit_vld, m_vld);
        if (m_vld) chk("hit_dat", hit_dat, m_dat);
        chk("err", err, m_err);
        @(posedge clk);
        if (r) begin
            m_open = '0;
            m_vld  = 1'b0;
            m_err  = 1'b0;
            m_dat  = '0;
            for (int i = 0; i < N; i++) m_q[i].delete();
        end else begin
            take = m_vld && hr;
            nv   = 1'b0;
            nd   = '0;
            if (rf) begin
                if (!m_open[rrid]) begin
                    m_err = 1'b1;
                end else begin
                    m_q[rrid].push_back('{rh, rt, ru, rvv});
                    if (rc) begin
                        nd = best_of(rrid);
                        nv = 1'b1;
                        m_open[rrid] = 1'b0;
                    end
                end
            end
            if (jf) begin
                if (jcnt == 0) begin
                    nd = mk(jrid, 1'b0, 32'h0, 32'h0, 32'h0);
                    nv = 1'b1;
                end else begin
                    m_open[jrid] = 1'b1;
                    m_cnt[jrid]  = jcnt;
                    m_tmax[jrid] = jt;
                    m_q[jrid].delete();
                end
            end
            if (nv) begin
                m_vld = 1'b1;
                m_dat = nd;
            end else if (take) begin
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic idle(input logic hr);
        step(1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 0, 1'b0, 32'h0, hr);
    endtask

    initial begin
        m_open = '0; m_vld = 1'b0; m_err = 1'b0; m_dat = '0;
        tset = '{32'h3F000000, 32'h3F800000, 32'h40000000, 32'h40400000};

        vt[0]  = '{1, 3, 3, 32'h7F800000, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[1]  = '{0, 0, 0, 32'h0,        1, 3, 1, 32'h40400000, 0, 0, 0, 32'h0};
        vt[2]  = '{0, 0, 0, 32'h0,        1, 3, 1, 32'h3F800000, 0, 0, 0, 32'h0};
        vt[3]  = '{0, 0, 0, 32'h0,        1, 3, 0, 32'h3F000000, 1, 3, 1, 32'h3F800000};
        vt[4]  = '{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[5]  = '{1, 1, 2, 32'h40000000, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[6]  = '{0, 0, 0, 32'h0,        1, 1, 1, 32'h40400000, 0, 0, 0, 32'h0};
        vt[7]  = '{0, 0, 0, 32'h0,        1, 1, 1, 32'h40000000, 1, 1, 0, 32'h0};
        vt[8]  = '{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[9]  = '{1, 5, 0, 32'h7F800000, 0, 0, 0, 32'h0,        1, 5, 0, 32'h0};
        vt[10] = '{1, 5, 0, 32'h7F800000, 0, 0, 0, 32'h0,        1, 5, 0, 32'h0};
        vt[11] = '{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[12] = '{1, 6, 3, 32'h7F800000, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0};
        vt[13] = '{0, 0, 0, 32'h0,        1, 6, 1, 32'h40000000, 0, 0, 0, 32'h0};
        vt[14] = '{0, 0, 0, 32'h0,        1, 6, 1, 32'h40000000, 0, 0, 0, 32'h0};
        vt[15] = '{0, 0, 0, 32'h0,        1, 6, 0, 32'h3F000000, 1, 6, 1, 32'h40000000};
        vt[16] = '{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0};

        // Reset state; a job offered during reset must not be taken.
        step(1'b1, 1'b0, 0, 0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 0, 1, 32'h7F800000, 1'b1, 0, 1'b1, 32'h0, 1'b1);
        #1;
        chk("rst_hit_vld", hit_vld, 1'b0);
        chk("rst_hit_dat", hit_dat, '0);
        chk("rst_err", err, 1'b0);

        for (int i = 0; i < 17; i++) begin
            step(1'b0, vt[i].jv, vt[i].jrid, vt[i].jcnt, vt[i].jt,
                 vt[i].rv, vt[i].rrid, vt[i].rh, vt[i].rt, 1'b1);
            #1;
            chk("vec_vld", hit_vld, vt[i].ev);
            if (vt[i].ev) begin
                chk("vec_rid", hit_dat[RW-1:0], RW'(vt[i].erid));
                chk("vec_hit", hit_dat[RW], vt[i].eh);
                chk("vec_t", hit_dat[RW+1 +: 32], vt[i].et);
            end
        end

        // Interleaved rays with the output stalled for five cycles.
        step(1'b0, 1'b1, 0, 2, 32'h7F800000, 1'b0, 0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1, 2, 32'h7F800000, 1'b0, 0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 32'h0, 1'b1, 0, 1'b1, 32'h40000000, 1'b0);
        step(1'b0, 1'b0, 0, 0, 32'h0, 1'b1, 0, 1'b1, 32'h3F000000, 1'b0);
        #1;
        saved = hit_dat;
        chk("stall_first_vld", hit_vld, 1'b1);
        chk("stall_first_rid", saved[RW-1:0], RW'(0));
        chk("stall_first_t", saved[RW+1 +: 32], 32'h3F000000);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 0, 0, 32'h0, 1'b1, 1, 1'b1, 32'h3F800000, 1'b0);
            #1;
            chk("stall_dat", hit_dat, saved);
        end
        step(1'b0, 1'b0, 0, 0, 32'h0, 1'b1, 1, 1'b1, 32'h3F800000, 1'b1);
        step(1'b0, 1'b0, 0, 0, 32'h0, 1'b1, 1, 1'b1, 32'h40800000, 1'b1);
        #1;
        chk("second_rid", hit_dat[RW-1:0], RW'(1));
        chk("second_t", hit_dat[RW+1 +: 32], 32'h3F800000);
        idle(1'b1);

        // Response for idle rid 7: sticky err, no output, rid 7 still usable.
        step(1'b0, 1'b0, 0, 0, 32'h0, 1'b1, 7, 1'b1, 32'h3F800000, 1'b1);
        #1;
        chk("idle_err", err, 1'b1);
        chk("idle_no_out", hit_vld, 1'b0);
        for (int k = 0; k < 3; k++) idle(1'b1);
        step(1'b0, 1'b1, 7, 1, 32'h7F800000, 1'b0, 0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 32'h0, 1'b1, 7, 1'b1, 32'h3F800000, 1'b1);
        #1;
        chk("rid7_vld", hit_vld, 1'b1);
        chk("rid7_rid", hit_dat[RW-1:0], RW'(7));
        chk("err_sticky", err, 1'b1);
        idle(1'b1);

        // Reset part-way through a ray drops it.
        step(1'b0, 1'b1, 2, 3, 32'h7F800000, 1'b0, 0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 32'h0, 1'b1, 2, 1'b1, 32'h3F800000, 1'b1);
        step(1'b1, 1'b0, 0, 0, 32'h0, 1'b1, 2, 1'b1, 32'h3F000000, 1'b1);
        #1;
        chk("midrst_vld", hit_vld, 1'b0);
        chk("midrst_err", err, 1'b0);
        step(1'b0, 1'b1, 2, 1, 32'h7F800000, 1'b0, 0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 32'h0, 1'b1, 2, 1'b1, 32'h40000000, 1'b1);
        #1;
        chk("reopen_vld", hit_vld, 1'b1);
        chk("reopen_t", hit_dat[RW+1 +: 32], 32'h40000000);
        idle(1'b1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            int rrid = $urandom_range(0, N-1);
            logic [31:0] jt = ($urandom_range(0, 1) == 0) ? 32'h7F800000 : tset[$urandom_range(0, 3)];
            if (m_open != '0 && $urandom_range(0, 9) != 0) begin
                for (int k = 0; k < 32 && !m_open[rrid]; k++) rrid = $urandom_range(0, N-1);
            end
            step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, N-1),
                 $urandom_range(0, 3), jt, $urandom_range(0, 9) < 7, rrid,
                 $urandom_range(0, 9) < 6, tset[$urandom_range(0, 3)], $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 4; k++) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
